// File: rtl/m_mem_exc_check.sv
// m_mem_exc_check: M-stage load/store address-exception checker with a one-entry CP0 record
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_we/req_size/req_addr/req_pc/req_ovf : M-stage memory request
//   flush            : discards any pending record
//   mem_kill         : combinational kill of DM/device access this cycle
//   exc_valid/exc_code/exc_badvaddr/exc_pc : pending record, held until exc_ack
//   exc_ack          : CP0 consumed the record
//   stat_adel/stat_ades/stat_drop : saturating counters, built only with MEM_EXC_STAT_EN
module m_mem_exc_check #(
    parameter logic [31:0]          DM_LAST    = 32'h0000_2fff,
    parameter int                   DEV_NUM    = 3,
    parameter logic [DEV_NUM*32-1:0] DEV_BASE  = {32'h7f20, 32'h7f10, 32'h7f00},
    parameter logic [DEV_NUM*32-1:0] DEV_LAST  = {32'h7f23, 32'h7f1b, 32'h7f0b},
    parameter logic [DEV_NUM-1:0]   TIMER_MASK = 3'b011,
    parameter int                   CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_pc,
    input  logic             req_ovf,
    input  logic             flush,
    output logic             mem_kill,
    output logic             exc_valid,
    output logic [4:0]       exc_code,
    output logic [31:0]      exc_badvaddr,
    output logic [31:0]      exc_pc,
    input  logic             exc_ack,
    output logic [CNT_W-1:0] stat_adel,
    output logic [CNT_W-1:0] stat_ades,
    output logic [CNT_W-1:0] stat_drop
);
    typedef enum logic {IDLE, PEND} state_t;

    state_t       state_q, state_d;
    logic [4:0]   code_q, code_d;
    logic [31:0]  bad_q, bad_d, pc_q, pc_d;
    logic [DEV_NUM-1:0] dev_hit, dev_tmr;
    logic         unalign, err, capture, drop;

    // req_size[1] set means word (size 3 is treated as word)
    for (genvar g = 0; g < DEV_NUM; g++) begin : g_dev
        assign dev_hit[g] = req_addr >= DEV_BASE[g*32 +: 32] && req_addr <= DEV_LAST[g*32 +: 32];
        assign dev_tmr[g] = TIMER_MASK[g] & dev_hit[g] &
                            (~req_size[1] | (req_we & (req_addr == DEV_BASE[g*32 +: 32] + 32'd8)));
    end

    assign unalign  = req_size[1] ? |req_addr[1:0] : req_size[0] & req_addr[0];
    assign err      = unalign | ~(req_addr <= DM_LAST || |dev_hit) | |dev_tmr | req_ovf;
    assign mem_kill = req_valid & err;

    always_comb begin
        capture = mem_kill & ~flush & (state_q == IDLE | exc_ack);
        drop    = mem_kill & ~flush & state_q == PEND & ~exc_ack;
        state_d = flush ? IDLE : capture ? PEND : exc_ack ? IDLE : state_q;
        code_d  = capture ? (req_we ? 5'd5 : 5'd4) : code_q;
        bad_d   = capture ? req_addr : bad_q;
        pc_d    = capture ? req_pc : pc_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            bad_q   <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            bad_q   <= bad_d;
            pc_q    <= pc_d;
        end
    end

    assign exc_valid    = state_q == PEND;
    assign exc_code     = code_q;
    assign exc_badvaddr = bad_q;
    assign exc_pc       = pc_q;

`ifdef MEM_EXC_STAT_EN
    logic [CNT_W-1:0] adel_q, adel_d, ades_q, ades_d, drop_q, drop_d;

    always_comb begin
        adel_d = (mem_kill & ~req_we & ~&adel_q) ? adel_q + CNT_W'(1) : adel_q;
        ades_d = (mem_kill &  req_we & ~&ades_q) ? ades_q + CNT_W'(1) : ades_q;
        drop_d = (drop & ~&drop_q) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adel_q <= '0;
            ades_q <= '0;
            drop_q <= '0;
        end else begin
            adel_q <= adel_d;
            ades_q <= ades_d;
            drop_q <= drop_d;
        end
    end

    assign stat_adel = adel_q;
    assign stat_ades = ades_q;
    assign stat_drop = drop_q;
`else
    assign stat_adel = '0;
    assign stat_ades = '0;
    assign stat_drop = '0;
`endif
endmodule

// File: tb/tb_m_mem_exc_check.sv
// tb_m_mem_exc_check: scoreboard bench for m_mem_exc_check against a rule-level model
module tb_m_mem_exc_check;
    localparam int CW = 4;

    logic          clk = 0, reset = 0;
    logic          req_valid = 0, req_we = 0, req_ovf = 0, flush = 0, exc_ack = 0;
    logic [1:0]    req_size = 0;
    logic [31:0]   req_addr = 0, req_pc = 0;
    logic          mem_kill, exc_valid;
    logic [4:0]    exc_code;
    logic [31:0]   exc_badvaddr, exc_pc;
    logic [CW-1:0] stat_adel, stat_ades, stat_drop;

    m_mem_exc_check #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_pc(req_pc), .req_ovf(req_ovf),
        .flush(flush), .mem_kill(mem_kill), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_badvaddr(exc_badvaddr), .exc_pc(exc_pc), .exc_ack(exc_ack),
        .stat_adel(stat_adel), .stat_ades(stat_ades), .stat_drop(stat_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kill; bit vld; bit [4:0] code; bit [31:0] bad; bit [31:0] pc;
        int adel; int ades; int drop;
    } exp_t;

    exp_t sbq[$];
    int errors = 0, checks = 0;

    int unsigned dev_base[3] = '{32'h7f00, 32'h7f10, 32'h7f20};
    int unsigned dev_last[3] = '{32'h7f0b, 32'h7f1b, 32'h7f23};
    bit          dev_tmr[3]  = '{1'b1, 1'b1, 1'b0};

    bit        m_pend;
    bit [4:0]  m_code;
    bit [31:0] m_bad, m_pc;
    int        m_adel, m_ades, m_drop;

    function automatic bit ref_err(bit we, bit [1:0] sz, bit [31:0] a, bit ovf);
        int unsigned bytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        bit inr = a <= 32'h2fff;
        bit tm = 0;
        for (int i = 0; i < 3; i++)
            if (a >= dev_base[i] && a <= dev_last[i]) begin
                inr = 1;
                if (dev_tmr[i] && (bytes < 4 || (we && a == dev_base[i] + 8))) tm = 1;
            end
        return (a % bytes != 0) || !inr || tm || ovf;
    endfunction

    function automatic int st(int v);
`ifdef MEM_EXC_STAT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int sat(int v);
        return (v + 1 > 15) ? 15 : v + 1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t snap(bit kill);
        exp_t e;
        e.kill = kill; e.vld = m_pend; e.code = m_code; e.bad = m_bad; e.pc = m_pc;
        e.adel = st(m_adel); e.ades = st(m_ades); e.drop = st(m_drop);
        return e;
    endfunction

    always @(negedge clk)
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("mem_kill", 64'(mem_kill), 64'(e.kill));
            chk("exc_valid", 64'(exc_valid), 64'(e.vld));
            chk("exc_code", 64'(exc_code), 64'(e.code));
            chk("exc_badvaddr", 64'(exc_badvaddr), 64'(e.bad));
            chk("exc_pc", 64'(exc_pc), 64'(e.pc));
            chk("stat_adel", 64'(stat_adel), 64'(e.adel));
            chk("stat_ades", 64'(stat_ades), 64'(e.ades));
            chk("stat_drop", 64'(stat_drop), 64'(e.drop));
        end

    task automatic cyc(bit v, bit we, bit [1:0] sz, bit [31:0] a, bit ovf, bit fl, bit ack);
        bit kill;
        bit [31:0] pc = $urandom;
        @(posedge clk); #1;
        req_valid = v; req_we = we; req_size = sz; req_addr = a; req_pc = pc;
        req_ovf = ovf; flush = fl; exc_ack = ack;
        kill = v && ref_err(we, sz, a, ovf);
        sbq.push_back(snap(kill));
        if (kill) begin
            if (we) m_ades = sat(m_ades); else m_adel = sat(m_adel);
        end
        if (fl) m_pend = 0;
        else if (kill && (!m_pend || ack)) begin
            m_pend = 1; m_code = we ? 5 : 4; m_bad = a; m_pc = pc;
        end else if (m_pend && ack) m_pend = 0;
        else if (m_pend && kill) m_drop = sat(m_drop);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        req_valid = 0; flush = 0; exc_ack = 0;
        #1 reset = 0;
        #1;
        chk("async_rst_valid", 64'(exc_valid), 64'd0);
        chk("async_rst_code", 64'(exc_code), 64'd0);
        chk("async_rst_bad", 64'(exc_badvaddr), 64'd0);
        chk("async_rst_pc", 64'(exc_pc), 64'd0);
        m_pend = 0; m_code = 0; m_bad = 0; m_pc = 0; m_adel = 0; m_ades = 0; m_drop = 0;
        sbq.push_back(snap(0));
        #1 reset = 1;
    endtask

    function automatic bit [31:0] rnd_addr();
        case ($urandom % 6)
            0: return $urandom;
            1: return $urandom_range(0, 32'h3010);
            2: return 32'h7f00 + ($urandom % 32'h30);
            3: return dev_base[$urandom % 3] + 8;
            4: return 32'hfffffffc + ($urandom % 4);
            default: return 32'h2ff8 + ($urandom % 16);
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1;
        sbq.push_back(snap(0));
        cyc(1, 0, 2, 32'h0000_0002, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 1, 32'h0000_7f04, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 32'h0000_7f18, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 2, 32'h0000_7f18, 0, 0, 0);
        cyc(1, 0, 0, 32'h0000_7f20, 0, 0, 0);
        cyc(1, 0, 2, 32'h0000_3000, 0, 0, 0);
        cyc(1, 1, 2, 32'h0000_3001, 0, 0, 0);
        cyc(1, 1, 0, 32'h0000_5000, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 2, 32'h0000_0001, 0, 1, 0);
        cyc(1, 0, 2, 32'h0000_2ffc, 0, 0, 0);
        cyc(1, 0, 0, 32'h0000_2fff, 0, 0, 0);
        cyc(1, 0, 0, 32'h0000_7f0b, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 2, 32'h0000_7f0c, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 3, 32'h0000_0010, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 2, 32'h0000_3000, 0, 0, 0);
        reset_pulse();
        for (int i = 0; i < 17; i++) cyc(1, 0, 2, 32'h0000_3000, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 1500; i++)
            cyc(($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), rnd_addr(),
                ($urandom % 16) == 0, ($urandom % 12) == 0, ($urandom % 3) == 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        chk("queue_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
